// File: rtl/hpi_bus_bridge.sv
// -----------------------------------------------------------------------------
// hpi_bus_bridge
//   Bridges a single-master valid/ready request port to an asynchronous-SRAM
//   style host port interface (CS_N/RD_N/WR_N/ADDR plus a tristate DATA bus).
//   An FSM walks IDLE -> SETUP -> STROBE -> HOLD -> IDLE, skipping zero-length
//   phases, with one shared down-counter reloaded on every phase change. Each
//   finished transaction produces a one-cycle rsp_valid pulse; reads also
//   return the sampled bus data on rsp_rdata.
//
// Ports
//   Clk, Reset              clock, synchronous active-high reset
//   req_valid/req_ready     request handshake (ready only while IDLE)
//   req_write/addr/wdata    request type, HPI address, write data
//   rsp_valid/rsp_rdata     completion pulse, last read data
//   bus_data                HPI data, driven by the bridge only during writes
//   bus_addr/cs_n/rd_n/wr_n HPI address, chip select and strobes
//   bus_rst_n               HPI reset, low while Reset is high
//
// Configuration
//   HPI_BRIDGE_STATS_EN     when defined, adds stat_clr/rd_count/wr_count:
//                           saturating 16-bit completion counters.
// -----------------------------------------------------------------------------
module hpi_bus_bridge #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 2,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  inout  wire  [DATA_W-1:0] bus_data,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_cs_n,
  output logic              bus_rd_n,
  output logic              bus_wr_n,
  output logic              bus_rst_n
`ifdef HPI_BRIDGE_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam int MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int MAX_CYC = (STROBE_CYC > MAX_SH) ? STROBE_CYC : MAX_SH;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Counter reload values: a phase of N cycles ends when the counter reaches 0.
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'((SETUP_CYC  > 0) ? SETUP_CYC  - 1 : 0);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'((STROBE_CYC > 0) ? STROBE_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'((HOLD_CYC   > 0) ? HOLD_CYC   - 1 : 0);

  if (STROBE_CYC < 1) begin : g_bad_strobe
    $error("hpi_bus_bridge: STROBE_CYC must be >= 1");
  end

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cs_n_q, cs_n_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic              drive_q, drive_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              rst_n_q;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              finish;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    cs_n_d      = cs_n_q;
    rd_n_d      = rd_n_q;
    wr_n_d      = wr_n_q;
    drive_d     = drive_q;
    addr_d      = addr_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    finish      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cs_n_d  = 1'b0;
          drive_d = req_write;
          if (SETUP_CYC > 0) begin
            state_d = SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            // No setup phase: strobe falls together with chip select.
            state_d = STROBE;
            cnt_d   = STROBE_LD;
            rd_n_d  = req_write;
            wr_n_d  = ~req_write;
          end
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LD;
          rd_n_d  = write_q;
          wr_n_d  = ~write_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          rd_n_d = 1'b1;
          wr_n_d = 1'b1;
          // Sample on the same edge that releases RD_N: data is still valid.
          if (!write_q) rdata_d = bus_data;
          if (HOLD_CYC > 0) begin
            state_d = HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            finish = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin  // HOLD
        if (cnt_q == '0) finish = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
    endcase

    if (finish) begin
      state_d     = IDLE;
      cnt_d       = '0;
      cs_n_d      = 1'b1;
      drive_d     = 1'b0;
      rsp_valid_d = 1'b1;
    end

    // Registered ready: high in every cycle the FSM sits in IDLE, including
    // the rsp_valid cycle, so back-to-back requests lose only one cycle.
    ready_d = (state_d == IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      drive_q     <= 1'b0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      rst_n_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      drive_q     <= drive_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      rst_n_q     <= 1'b1;
    end
  end

  // NOTE: the latched request type and write data need no reset; they are only
  // observed while drive_q, a strobe or rsp_valid_q (all reset) qualify them.
  always_ff @(posedge Clk) begin
    write_q <= write_d;
    wdata_q <= wdata_d;
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign bus_addr  = addr_q;
  assign bus_cs_n  = cs_n_q;
  assign bus_rd_n  = rd_n_q;
  assign bus_wr_n  = wr_n_q;
  assign bus_rst_n = rst_n_q;
  assign bus_data  = drive_q ? wdata_q : {DATA_W{1'bz}};

`ifdef HPI_BRIDGE_STATS_EN
  logic [15:0] rd_count_q, wr_count_q;

  // write_q still describes the finished transaction during the rsp cycle;
  // a new accept can only change it on the edge that ends that cycle.
  always_ff @(posedge Clk) begin
    if (Reset || stat_clr) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (rsp_valid_q) begin
      if (write_q) begin
        if (wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
      end else begin
        if (rd_count_q != 16'hFFFF) rd_count_q <= rd_count_q + 16'd1;
      end
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_hpi_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_hpi_bus_bridge
//   Directed bench for hpi_bus_bridge at default timing (setup 1, strobe 4,
//   hold 1). A small HPI device model returns 16'h1234 while RD_N is low and,
//   when probing is enabled, otherwise drives 16'h5A3C so that any unwanted
//   drive from the bridge (which holds complementary data) corrupts the bus.
// -----------------------------------------------------------------------------
module tb_hpi_bus_bridge;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  wire  [15:0] bus_data;
  logic [1:0]  bus_addr;
  logic        bus_cs_n;
  logic        bus_rd_n;
  logic        bus_wr_n;
  logic        bus_rst_n;
`ifdef HPI_BRIDGE_STATS_EN
  logic        stat_clr;
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  logic mdl_probe;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 Clk = ~Clk;

  assign bus_data = (!bus_rd_n) ? 16'h1234 : (mdl_probe ? 16'h5A3C : 16'hzzzz);

  hpi_bus_bridge dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .bus_data  (bus_data),
    .bus_addr  (bus_addr),
    .bus_cs_n  (bus_cs_n),
    .bus_rd_n  (bus_rd_n),
    .bus_wr_n  (bus_wr_n),
    .bus_rst_n (bus_rst_n)
`ifdef HPI_BRIDGE_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
`endif
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 2'd0;
    req_wdata = 16'h0000;
    mdl_probe = 1'b0;
`ifdef HPI_BRIDGE_STATS_EN
    stat_clr  = 1'b0;
`endif

    // ---- reset for three cycles, then release ----
    repeat (3) tick();
    check("rst_bus_rst_n", 32'(bus_rst_n), 32'd0);
    check("rst_ready",     32'(req_ready), 32'd0);
    check("rst_cs_n",      32'(bus_cs_n),  32'd1);
    check("rst_rd_n",      32'(bus_rd_n),  32'd1);
    check("rst_wr_n",      32'(bus_wr_n),  32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata",     32'(rsp_rdata), 32'h0);
    check("rst_addr",      32'(bus_addr),  32'd0);
    Reset = 1'b0;
    tick();
    check("rel_bus_rst_n", 32'(bus_rst_n), 32'd1);
    check("rel_ready",     32'(req_ready), 32'd1);

    // ---- single write: addr 2, data A5C3 ----
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 2'd2;
    req_wdata = 16'hA5C3;
    tick();                       // accept edge (k = 0)
    req_valid = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) tick();
      if (k == 6) begin
        mdl_probe = 1'b1;         // bridge must have released the bus
        #1;
      end
      check($sformatf("wr_cs_n_k%0d", k),  32'(bus_cs_n),  (k < 6) ? 32'd0 : 32'd1);
      check($sformatf("wr_wr_n_k%0d", k),  32'(bus_wr_n),  (k >= 1 && k <= 4) ? 32'd0 : 32'd1);
      check($sformatf("wr_rd_n_k%0d", k),  32'(bus_rd_n),  32'd1);
      check($sformatf("wr_rsp_k%0d", k),   32'(rsp_valid), (k == 6) ? 32'd1 : 32'd0);
      check($sformatf("wr_ready_k%0d", k), 32'(req_ready), (k >= 6) ? 32'd1 : 32'd0);
      if (k < 6) begin
        check($sformatf("wr_addr_k%0d", k), 32'(bus_addr), 32'd2);
        check($sformatf("wr_data_k%0d", k), 32'(bus_data), 32'hA5C3);
      end else begin
        check($sformatf("wr_data_off_k%0d", k), 32'(bus_data), 32'h5A3C);
      end
    end

    // ---- single read: addr 1, device returns 1234 ----
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 2'd1;
    req_wdata = 16'hA5C3;
    tick();
    req_valid = 1'b0;
    check("rd_rdata_before", 32'(rsp_rdata), 32'h0);
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) tick();
      check($sformatf("rd_cs_n_k%0d", k), 32'(bus_cs_n),  (k < 6) ? 32'd0 : 32'd1);
      check($sformatf("rd_rd_n_k%0d", k), 32'(bus_rd_n),  (k >= 1 && k <= 4) ? 32'd0 : 32'd1);
      check($sformatf("rd_wr_n_k%0d", k), 32'(bus_wr_n),  32'd1);
      check($sformatf("rd_rsp_k%0d", k),  32'(rsp_valid), (k == 6) ? 32'd1 : 32'd0);
      check($sformatf("rd_data_k%0d", k), 32'(bus_data),
            (k >= 1 && k <= 4) ? 32'h1234 : 32'h5A3C);
      if (k < 6) check($sformatf("rd_addr_k%0d", k), 32'(bus_addr), 32'd1);
      if (k >= 5) check($sformatf("rd_rdata_k%0d", k), 32'(rsp_rdata), 32'h1234);
    end

    // ---- three back-to-back writes with req_valid held high ----
    mdl_probe = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 2'd3;
    req_wdata = 16'h0F0F;
    tick();                       // first accept (k = 0); later at k = 7, 14
    for (int k = 0; k <= 21; k++) begin
      if (k > 0) tick();
      if (k == 14) req_valid = 1'b0;
      check($sformatf("b2b_cs_n_k%0d", k), 32'(bus_cs_n),
            (k == 6 || k == 13 || k >= 20) ? 32'd1 : 32'd0);
      check($sformatf("b2b_wr_n_k%0d", k), 32'(bus_wr_n),
            ((k % 7) >= 1 && (k % 7) <= 4 && k < 20) ? 32'd0 : 32'd1);
      check($sformatf("b2b_rd_n_k%0d", k), 32'(bus_rd_n), 32'd1);
      check($sformatf("b2b_rsp_k%0d", k), 32'(rsp_valid),
            (k == 6 || k == 13 || k == 20) ? 32'd1 : 32'd0);
      if (!(k == 6 || k == 13 || k >= 20))
        check($sformatf("b2b_data_k%0d", k), 32'(bus_data), 32'h0F0F);
    end

`ifdef HPI_BRIDGE_STATS_EN
    // one read and four writes have completed so far
    check("stat_rd_count", 32'(rd_count), 32'd1);
    check("stat_wr_count", 32'(wr_count), 32'd4);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("stat_rd_clr", 32'(rd_count), 32'd0);
    check("stat_wr_clr", 32'(wr_count), 32'd0);
`endif

    // ---- reset asserted during the strobe of a write ----
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 2'd2;
    req_wdata = 16'hA5C3;
    tick();                       // accept
    req_valid = 1'b0;
    tick();
    tick();                       // k = 2, strobe active
    check("abort_wr_n_pre", 32'(bus_wr_n), 32'd0);
    Reset = 1'b1;
    tick();
    mdl_probe = 1'b1;
    #1;
    check("abort_cs_n",      32'(bus_cs_n),  32'd1);
    check("abort_wr_n",      32'(bus_wr_n),  32'd1);
    check("abort_rd_n",      32'(bus_rd_n),  32'd1);
    check("abort_rsp",       32'(rsp_valid), 32'd0);
    check("abort_data",      32'(bus_data),  32'h5A3C);
    check("abort_addr",      32'(bus_addr),  32'd0);
    check("abort_bus_rst_n", 32'(bus_rst_n), 32'd0);
    check("abort_rdata",     32'(rsp_rdata), 32'h0);
    Reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("abort_no_rsp_%0d", k), 32'(rsp_valid), 32'd0);
      check($sformatf("abort_cs_hi_%0d", k),  32'(bus_cs_n),  32'd1);
    end
    check("abort_ready", 32'(req_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
